// File: rtl/lab1_pkg.sv
// Shared types and constants for the lab1 RAM edit sequencer.
// Key indices map the pushbuttons to their edit functions.
package lab1_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RD,
        WR,
        CLR
    } seq_state_t;

    localparam int K_ADDR_INC = 3;
    localparam int K_ADDR_DEC = 2;
    localparam int K_DATA_INC = 1;
    localparam int K_DATA_DEC = 0;

endpackage

// File: rtl/mem_edit_sequencer_debounce.sv
// Debouncer for one active-low pushbutton: the level follows raw only after
// it has differed for DEBOUNCE_CYCLES consecutive cycles; press pulses on 1->0.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw;
                press_d = ~raw;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/mem_edit_sequencer.sv
// Sequences address steps, read-modify-write edits and a clear sweep of the
// 16x8 board RAM from four debounced pushbuttons; drives a/din/we registered.
module mem_edit_sequencer
    import lab1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = DEFAULT_ADDR_W,
    parameter int DATA_W          = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        KEY,
    input  logic              clear,
    input  logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] din,
    output logic              we,
    output logic              busy
);

    logic [3:0] press;
    logic [3:0] unused_key_level;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (KEY[k]),
            .level(unused_key_level[k]),
            .press(press[k])
        );
    end

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              we_q, we_d;
    logic              dir_inc_q, dir_inc_d;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        din_d     = din_q;
        we_d      = we_q;
        dir_inc_d = dir_inc_q;
        unique case (state_q)
            IDLE: begin
                we_d = 1'b0;
                // Fixed priority; anything below the winner this cycle is dropped.
                if (clear) begin
                    a_d     = '0;
                    din_d   = '0;
                    we_d    = 1'b1;
                    state_d = CLR;
                end else if (press[K_ADDR_INC]) begin
                    a_d     = a_q + ADDR_W'(1);
                    state_d = SETTLE;
                end else if (press[K_ADDR_DEC]) begin
                    a_d     = a_q - ADDR_W'(1);
                    state_d = SETTLE;
                end else if (press[K_DATA_INC]) begin
                    dir_inc_d = 1'b1;
                    state_d   = RD;
                end else if (press[K_DATA_DEC]) begin
                    dir_inc_d = 1'b0;
                    state_d   = RD;
                end
            end
            SETTLE: state_d = IDLE;
            RD: begin
                din_d   = dir_inc_q ? dout + DATA_W'(1) : dout - DATA_W'(1);
                we_d    = 1'b1;
                state_d = WR;
            end
            WR: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
            CLR: begin
                if (a_q == '1) begin
                    we_d    = 1'b0;
                    a_d     = '0;
                    state_d = SETTLE;
                end else begin
                    a_d = a_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            dir_inc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            din_q     <= din_d;
            we_q      <= we_d;
            dir_inc_q <= dir_inc_d;
        end
    end

    assign a    = a_q;
    assign din  = din_q;
    assign we   = we_q;
    assign busy = (state_q != IDLE);

endmodule
